pid_tdm_sched: RTL and testbench
================================

# pid_tdm_sched

Time-division scheduler that shares one PID datapath among `N_CH` phase channels. It has a single signed multiplier and a single accumulator, plus per-channel integrator and previous-error state. A round-robin arbiter grants one channel's phase sample at a time, and a state machine steps the sample through error, P, I and D multiplies and the sum. It sits between the multi-channel phase detectors and the loop-filter consumers, and replaces one PID instance per channel.

## Interface
- `N_CH`, 4: number of channels, ≥2.
- `PHASE_WIDTH`, 10: phase input width (W).
- `PID_OWIDTH`, 9: output width, ≤ 2W−1.
- `INT_MAX`, 0: signed W-bit integrator clamp magnitude, positive.
- `K_PROD`, `K_INT`, `K_DIFF`, 0: signed W-bit gains.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `req_i`  in  N_CH: per-channel sample request, level, held until acked.
- `phase_i`  in  N_CH·W: channel c occupies bits [c·W +: W], unsigned fraction [0, 0.5).
- `ack_o`  out  N_CH: one-hot, one-cycle grant/accept pulse.
- `clr_i`  in  1: synchronous clear of all integrator and previous-error stores.
- `pid_o`  out  PID_OWIDTH: signed result, 1 sign bit, rest fractional.
- `pid_ch_o`  out  clog2(N_CH): channel of `pid_o`.
- `pid_valid_o`  out  1: one-cycle result strobe.

## Operation
- FSM states: IDLE → ERR → MUL_P → MUL_I → MUL_D → ACC → OUT → IDLE. IDLE is the only state that grants.
- **Arbiter**
  - In IDLE, if any `req_i` is high, grant the first requesting channel after the last granted channel, searching upward with wrap.
  - The last-granted pointer resets to N_CH−1, so ch0 has priority after reset.
  - On the grant edge, latch the channel index and its `phase_i` slice. Phase is sampled only at that edge.
- **ERR**
  - SET_POINT = 2^W/4 − 1.
  - e = bits [W:1] of the (W+1)-bit signed value SET_POINT − phase, giving W-bit signed e.
  - d = e − eprev[ch], kept to W bits (wrap).
  - int_new = clamp(int[ch] + e, −INT_MAX, +INT_MAX), computed at W+1 bits and stored as W bits.
- **Multiply/accumulate**
  - MUL_P: prod ← e·K_PROD.
  - MUL_I: prod ← int_new·K_INT; acc ← prod.
  - MUL_D: prod ← d·K_DIFF; acc ← acc + prod.
  - All products are 2W-bit signed. acc is 2W+1 bits.
- **ACC**
  - s = acc + prod, saturated to [−2^(2W−2), 2^(2W−2)−1].
  - pid_o ← {s[2W−1], s[2W−3 : 2W−PID_OWIDTH−1]}.
  - pid_ch_o ← ch.
  - Write back eprev[ch] ← e and int[ch] ← int_new.
- **Store isolation:** only the granted channel's stores change.
- **clr_i:** zeroes all stores. It has priority over a same-edge write-back. An in-flight sample completes using the values it already read.
- **Reset (async assert)**
  - state=IDLE; all stores, acc and prod = 0.
  - `ack_o`=0, `pid_valid_o`=0, `pid_o`=0, `pid_ch_o`=0.
  - Any in-flight sample is dropped with no result.
- Deasserting `req_i` before grant withdraws the request without error.

## Timing
- Grant edge E0 (IDLE with a request): `ack_o[ch]` is high for cycle E0–E1.
- `pid_o`, `pid_ch_o` update at E5. `pid_valid_o` is high for cycle E5–E6, in the OUT state.
- `pid_o` and `pid_ch_o` hold until the next E5.
- Latency is 5 cycles from the grant edge to the result. The next grant is possible at E7, so throughput is 1 sample per 7 cycles.
- With all N_CH requests held, the grant sequence is 0,1,…,N_CH−1,0,… at 7-cycle spacing.
- A request arriving during a busy sample waits; it is never lost.

## Test plan
Defaults unless noted: W=10, SET_POINT=255, PID_OWIDTH=9.
- **P only.** K_PROD=64, other gains 0; ch0 phase=0. Expected: e=127, product=8128, `pid_o`=7, `pid_ch_o`=0; `ack_o`=0001 at E0; `pid_valid_o` at E5. Repeat with phase=255: `pid_o`=0. Repeat with phase=511: e=−128, `pid_o`=−8.
- **I clamp and isolation.** K_INT=64, INT_MAX=100, other gains 0; ch1 phase=0 three times. Expected: `pid_o`=6 each time (int clamped at 100). A following ch2 phase=255 gives `pid_o`=0, confirming ch2 is unaffected.
- **D.** K_DIFF=64 only; ch0 phase=0 twice. Expected: `pid_o`=7, then 0. Then phase=511: d=−255, `pid_o`=−16.
- **Round-robin.** All `req_i` held from reset. Expected: `ack_o`=0001, 0010, 0100, 1000, 0001 at 7-cycle spacing; `pid_ch_o` follows the same order.
- **Async reset mid-sample.** Assert `rst_n` low during MUL_I. Expected: outputs go to 0 immediately, no `pid_valid_o`, integrators read 0 on the next samples.
- **clr_i.** Integrator at 100, then assert `clr_i` on the ACC edge. Expected: the in-flight result is still 6, the next sample reads int=0 then adds e, and the store is not overwritten.

Source files
------------

// File: rtl/pid_tdm_sched.sv
// Time-division PID scheduler: one signed multiplier and one accumulator shared by N_CH
// phase channels, granted round-robin, with per-channel integrator and previous-error stores.
module pid_tdm_sched #(
  parameter int N_CH        = 4,
  parameter int PHASE_WIDTH = 10,
  parameter int PID_OWIDTH  = 9,
  parameter int INT_MAX     = 0,
  parameter int K_PROD      = 0,
  parameter int K_INT       = 0,
  parameter int K_DIFF      = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_CH-1:0]              req_i,
  input  logic [N_CH*PHASE_WIDTH-1:0]  phase_i,
  output logic [N_CH-1:0]              ack_o,
  input  logic                         clr_i,
  output logic signed [PID_OWIDTH-1:0] pid_o,
  output logic [$clog2(N_CH)-1:0]      pid_ch_o,
  output logic                         pid_valid_o
);
  localparam int W  = PHASE_WIDTH;
  localparam int CW = $clog2(N_CH);
  localparam int PW = 2 * W;
  localparam int AW = 2 * W + 1;

  localparam logic signed [W:0]   SET_POINT = (W+1)'((1 << W) / 4 - 1);
  localparam logic signed [W:0]   INT_HI    = (W+1)'(INT_MAX);
  localparam logic signed [W:0]   INT_LO    = (W+1)'(-INT_MAX);
  localparam logic signed [W-1:0] KP        = W'(K_PROD);
  localparam logic signed [W-1:0] KI        = W'(K_INT);
  localparam logic signed [W-1:0] KD        = W'(K_DIFF);
  localparam logic signed [AW:0]  SAT_HI    = (AW+1)'((1 << (PW - 2)) - 1);
  localparam logic signed [AW:0]  SAT_LO    = (AW+1)'(-(1 << (PW - 2)));

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MUL_P, S_MUL_I, S_MUL_D, S_ACC, S_OUT
  } state_t;

  state_t state_q, state_d;

  // ch_q doubles as the last-granted pointer for the arbiter.
  logic [CW-1:0]        ch_q;
  logic [W-1:0]         phase_q;
  logic signed [W-1:0]  e_q, d_q, int_new_q;
  logic signed [PW-1:0] prod_q;
  logic signed [AW-1:0] acc_q;
  logic signed [W-1:0]  int_q   [N_CH];
  logic signed [W-1:0]  eprev_q [N_CH];

  logic                    grant_vld;
  logic [CW-1:0]           grant_ch, cand;
  logic [W-1:0]            grant_phase;
  logic signed [W:0]       diff_c, int_sum_c, int_sat_c;
  logic signed [W-1:0]     e_c, d_c;
  logic signed [AW:0]      sum_c, s_c;
  logic [PID_OWIDTH-1:0]   pid_c;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_vld) state_d = S_ERR;
      S_ERR:   state_d = S_MUL_P;
      S_MUL_P: state_d = S_MUL_I;
      S_MUL_I: state_d = S_MUL_D;
      S_MUL_D: state_d = S_ACC;
      S_ACC:   state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scan from farthest to nearest so the final hit is the first requester after ch_q.
  always_comb begin
    grant_vld   = 1'b0;
    grant_ch    = ch_q;
    cand        = '0;
    grant_phase = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand = CW'((int'(ch_q) + k) % N_CH);
      if (req_i[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
    for (int c = 0; c < N_CH; c++)
      if (grant_ch == CW'(c)) grant_phase = phase_i[c*W +: W];
  end

  always_comb begin
    diff_c    = SET_POINT - (W+1)'(phase_q);
    e_c       = W'(diff_c >>> 1);
    d_c       = e_c - eprev_q[ch_q];
    int_sum_c = (W+1)'(int_q[ch_q]) + (W+1)'(e_c);
    if (int_sum_c > INT_HI)      int_sat_c = INT_HI;
    else if (int_sum_c < INT_LO) int_sat_c = INT_LO;
    else                         int_sat_c = int_sum_c;

    sum_c = (AW+1)'(acc_q) + (AW+1)'(prod_q);
    if (sum_c > SAT_HI)      s_c = SAT_HI;
    else if (sum_c < SAT_LO) s_c = SAT_LO;
    else                     s_c = sum_c;
    // After saturation s[2W-2] equals the sign, so the arithmetic shift yields {sign, fraction}.
    pid_c = PID_OWIDTH'(s_c >>> (PW - PID_OWIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q        <= CW'(N_CH - 1);
      phase_q     <= '0;
      e_q         <= '0;
      d_q         <= '0;
      int_new_q   <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      ack_o       <= '0;
      pid_o       <= '0;
      pid_ch_o    <= '0;
      pid_valid_o <= 1'b0;
      // NOTE: the per-channel stores are small flop arrays, not RAM, so they take the reset too.
      for (int c = 0; c < N_CH; c++) begin
        int_q[c]   <= '0;
        eprev_q[c] <= '0;
      end
    end else begin
      ack_o       <= '0;
      pid_valid_o <= 1'b0;
      case (state_q)
        S_IDLE: if (grant_vld) begin
          ch_q    <= grant_ch;
          phase_q <= grant_phase;
          ack_o   <= N_CH'(1) << grant_ch;
        end
        S_ERR: begin
          e_q       <= e_c;
          d_q       <= d_c;
          int_new_q <= W'(int_sat_c);
        end
        S_MUL_P: prod_q <= PW'(e_q) * PW'(KP);
        S_MUL_I: begin
          prod_q <= PW'(int_new_q) * PW'(KI);
          acc_q  <= AW'(prod_q);
        end
        S_MUL_D: begin
          prod_q <= PW'(d_q) * PW'(KD);
          acc_q  <= acc_q + AW'(prod_q);
        end
        S_ACC: begin
          pid_o            <= pid_c;
          pid_ch_o         <= ch_q;
          pid_valid_o      <= 1'b1;
          eprev_q[ch_q]    <= e_q;
          int_q[ch_q]      <= int_new_q;
        end
        default: ;
      endcase
      // Placed last so a clear overrides a write-back on the same edge.
      if (clr_i) begin
        for (int c = 0; c < N_CH; c++) begin
          int_q[c]   <= '0;
          eprev_q[c] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_tdm_sched.sv
// Bench for pid_tdm_sched: directed and random samples checked against an arithmetic
// PID reference with per-channel integrator and previous-error state.
module tb_pid_tdm_sched;
  localparam int N_CH    = 4;
  localparam int W       = 10;
  localparam int OW      = 9;
  localparam int CW      = 2;
  localparam int INT_MAX = 300;
  localparam int KP      = 511;
  localparam int KI      = 256;
  localparam int KD      = 511;
  localparam int SETP    = (1 << W) / 4 - 1;
  localparam int SAT     = 1 << (2 * W - 2);
  localparam int SHIFT   = 2 * W - OW - 1;
  localparam logic [N_CH*W-1:0] LANE = (N_CH*W)'((1 << W) - 1);

  logic                 clk, rst_n, clr;
  logic [N_CH-1:0]      req, ack;
  logic [N_CH*W-1:0]    phase;
  logic signed [OW-1:0] pid;
  logic [CW-1:0]        pid_ch;
  logic                 valid;

  int errors = 0;
  int checks = 0;
  int m_int   [N_CH];
  int m_eprev [N_CH];

  pid_tdm_sched #(
    .N_CH(N_CH), .PHASE_WIDTH(W), .PID_OWIDTH(OW), .INT_MAX(INT_MAX),
    .K_PROD(KP), .K_INT(KI), .K_DIFF(KD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .phase_i(phase), .ack_o(ack),
    .clr_i(clr), .pid_o(pid), .pid_ch_o(pid_ch), .pid_valid_o(valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  function automatic void model_clear();
    for (int c = 0; c < N_CH; c++) begin
      m_int[c]   = 0;
      m_eprev[c] = 0;
    end
  endfunction

  // Reference PID step: error halved from the set point, wrapped derivative, clamped
  // integrator, saturated sum scaled down to the output fraction.
  function automatic int model_step(input int ch, input int ph, input bit clr_now);
    int e, d, inew, s;
    e = (SETP - ph) >>> 1;
    d = e - m_eprev[ch];
    d = ((d + (1 << (W - 1))) & ((1 << W) - 1)) - (1 << (W - 1));
    inew = m_int[ch] + e;
    if (inew > INT_MAX) inew = INT_MAX;
    else if (inew < -INT_MAX) inew = -INT_MAX;
    s = e * KP + inew * KI + d * KD;
    if (s > SAT - 1) s = SAT - 1;
    else if (s < -SAT) s = -SAT;
    if (clr_now) model_clear();
    else begin
      m_eprev[ch] = e;
      m_int[ch]   = inew;
    end
    return s >>> SHIFT;
  endfunction

  task automatic set_phase(input int ch, input int ph);
    phase = (phase & ~(LANE << (ch * W))) | (((N_CH*W)'(ph) & LANE) << (ch * W));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    clr   = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_clear();
  endtask

  // Runs one sample on one channel and reports what the DUT did; lat is -1 on timeout.
  task automatic do_sample(input int ch, input int ph, input bit clr_acc,
                           output logic [N_CH-1:0] ack_seen, output int lat,
                           output logic signed [OW-1:0] pid_seen,
                           output logic [CW-1:0] ch_seen, output bit held);
    int waited;
    waited   = 0;
    ack_seen = '0;
    lat      = -1;
    pid_seen = 'x;
    ch_seen  = 'x;
    held     = 1'b0;
    set_phase(ch, ph);
    req = req | (N_CH'(1) << ch);
    while (ack_seen === '0 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
      ack_seen = ack;
    end
    req = req & ~(N_CH'(1) << ch);
    if (ack_seen === '0) return;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      if (clr_acc && i == 5) clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      if (valid === 1'b1) lat = i;
    end
    if (lat < 0) return;
    pid_seen = pid;
    ch_seen  = pid_ch;
    @(posedge clk); #1;
    held = (valid === 1'b0) && (pid === pid_seen) && (pid_ch === ch_seen);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    clr   = 1'b0;
    phase = '0;
    #3;
    checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (pid !== '0) begin errors++; $display("FAIL reset_pid: got %0d want 0", pid); end
    checks++; if (pid_ch !== '0) begin errors++; $display("FAIL reset_ch: got %0d want 0", pid_ch); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || ack !== '0) begin
      errors++; $display("FAIL idle_quiet: got ack=%b valid=%b want 0/0", ack, valid);
    end
  endtask

  // Integrator clamp at both limits, output saturation at both limits, channel isolation.
  task automatic test_saturation();
    int chs [11] = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 3};
    int phs [11] = '{0, 0, 0, 511, 0, 511, 511, 511, 0, 511, 255};
    int lit [11] = '{0, 0, 138, 0, 255, 0, 0, -139, 0, -256, 0};
    bit has [11] = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic [N_CH-1:0] a;
    logic signed [OW-1:0] p;
    logic [CW-1:0] c;
    int lat, exp;
    bit held;
    for (int k = 0; k < 11; k++) begin
      do_sample(chs[k], phs[k], 1'b0, a, lat, p, c, held);
      exp = model_step(chs[k], phs[k], 1'b0);
      checks++;
      if (a !== N_CH'(1 << chs[k])) begin
        errors++; $display("FAIL sat_ack[%0d]: got %b want %b", k, a, N_CH'(1 << chs[k]));
      end
      checks++;
      if (p !== OW'(exp)) begin
        errors++; $display("FAIL sat_pid[%0d]: got %0d want %0d", k, p, exp);
      end
      if (has[k]) begin
        checks++;
        if (p !== OW'(lit[k])) begin
          errors++; $display("FAIL sat_const[%0d]: got %0d want %0d", k, p, lit[k]);
        end
      end
    end
  endtask

  // Clear on the ACC edge: in-flight result uses the old stores, later samples start from zero.
  task automatic test_clear();
    int chs [6] = '{0, 0, 0, 0, 0, 1};
    int phs [6] = '{0, 0, 0, 0, 0, 255};
    bit clrs [6] = '{0, 0, 0, 1, 0, 0};
    int lit [6] = '{0, 0, 138, 138, 158, 0};
    logic [N_CH-1:0] a;
    logic signed [OW-1:0] p;
    logic [CW-1:0] c;
    int lat, exp;
    bit held;
    for (int k = 0; k < 6; k++) begin
      do_sample(chs[k], phs[k], clrs[k], a, lat, p, c, held);
      exp = model_step(chs[k], phs[k], clrs[k]);
      checks++;
      if (p !== OW'(exp)) begin
        errors++; $display("FAIL clr_pid[%0d]: got %0d want %0d", k, p, exp);
      end
      if (k >= 2) begin
        checks++;
        if (p !== OW'(lit[k])) begin
          errors++; $display("FAIL clr_const[%0d]: got %0d want %0d", k, p, lit[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [N_CH-1:0] a;
    logic signed [OW-1:0] p;
    logic [CW-1:0] c;
    int lat, exp, ch, ph;
    bit held, cl;
    for (int k = 0; k < 40; k++) begin
      ch = $urandom_range(0, N_CH - 1);
      ph = $urandom_range(0, 511);
      cl = ($urandom_range(0, 7) == 0);
      do_sample(ch, ph, cl, a, lat, p, c, held);
      exp = model_step(ch, ph, cl);
      checks++;
      if (a !== N_CH'(1 << ch)) begin
        errors++; $display("FAIL rnd_ack[%0d]: got %b want %b", k, a, N_CH'(1 << ch));
      end
      checks++;
      if (lat != 5) begin
        errors++; $display("FAIL rnd_latency[%0d]: got %0d want 5", k, lat);
      end
      checks++;
      if (p !== OW'(exp)) begin
        errors++; $display("FAIL rnd_pid[%0d]: ch %0d phase %0d got %0d want %0d", k, ch, ph, p, exp);
      end
      checks++;
      if (c !== CW'(ch)) begin
        errors++; $display("FAIL rnd_ch[%0d]: got %0d want %0d", k, c, ch);
      end
      checks++;
      if (!held) begin
        errors++; $display("FAIL rnd_strobe_hold[%0d]: strobe not single-cycle or result not held", k);
      end
    end
  endtask

  // All requests held from reset: grants rotate 0..N_CH-1 at 7-cycle spacing.
  task automatic test_round_robin();
    int ph [N_CH];
    logic [N_CH-1:0] g_ack [8];
    int g_cyc [8];
    int v_cyc [8];
    logic signed [OW-1:0] v_pid [8];
    logic [CW-1:0] v_ch [8];
    int ng, nv, cyc, exp;
    ng = 0;
    nv = 0;
    cyc = 0;
    apply_reset();
    for (int c = 0; c < N_CH; c++) begin
      ph[c] = $urandom_range(0, 511);
      set_phase(c, ph[c]);
    end
    req = '1;
    while (nv < 8 && cyc < 120) begin
      @(posedge clk); #1;
      cyc++;
      if (ack !== '0 && ng < 8) begin
        g_ack[ng] = ack;
        g_cyc[ng] = cyc;
        ng++;
      end
      if (valid === 1'b1) begin
        v_pid[nv] = pid;
        v_ch[nv]  = pid_ch;
        v_cyc[nv] = cyc;
        nv++;
      end
    end
    req = '0;
    checks++;
    if (nv != 8 || ng != 8) begin
      errors++; $display("FAIL rr_count: got %0d grants %0d results want 8/8", ng, nv);
    end
    for (int k = 0; k < nv && k < ng; k++) begin
      exp = model_step(k % N_CH, ph[k % N_CH], 1'b0);
      checks++;
      if (g_ack[k] !== N_CH'(1 << (k % N_CH))) begin
        errors++; $display("FAIL rr_ack[%0d]: got %b want %b", k, g_ack[k], N_CH'(1 << (k % N_CH)));
      end
      checks++;
      if (v_ch[k] !== CW'(k % N_CH)) begin
        errors++; $display("FAIL rr_ch[%0d]: got %0d want %0d", k, v_ch[k], k % N_CH);
      end
      checks++;
      if (v_pid[k] !== OW'(exp)) begin
        errors++; $display("FAIL rr_pid[%0d]: got %0d want %0d", k, v_pid[k], exp);
      end
      checks++;
      if (v_cyc[k] - g_cyc[k] != 5) begin
        errors++; $display("FAIL rr_latency[%0d]: got %0d want 5", k, v_cyc[k] - g_cyc[k]);
      end
      if (k > 0) begin
        checks++;
        if (g_cyc[k] - g_cyc[k-1] != 7) begin
          errors++; $display("FAIL rr_spacing[%0d]: got %0d want 7", k, g_cyc[k] - g_cyc[k-1]);
        end
      end
    end
    repeat (4) @(posedge clk);
  endtask

  // Reset asserted while the sample is in MUL_I: outputs clear at once, no result appears.
  task automatic test_async_reset();
    logic [N_CH-1:0] a;
    logic signed [OW-1:0] p;
    logic [CW-1:0] c;
    int lat, exp, waited;
    bit held, seen;
    do_sample(1, 0, 1'b0, a, lat, p, c, held);
    void'(model_step(1, 0, 1'b0));
    set_phase(1, 0);
    req = N_CH'(1 << 1);
    waited = 0;
    while (ack === '0 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    req = '0;
    checks++;
    if (ack === '0) begin
      errors++; $display("FAIL arst_grant: got no grant want ack");
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (ack !== '0) begin errors++; $display("FAIL arst_ack: got %b want 0", ack); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", valid); end
    checks++; if (pid !== '0) begin errors++; $display("FAIL arst_pid: got %0d want 0", pid); end
    checks++; if (pid_ch !== '0) begin errors++; $display("FAIL arst_ch: got %0d want 0", pid_ch); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_clear();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL arst_dropped: got a result strobe want none");
    end
    for (int k = 1; k <= 2; k++) begin
      do_sample(k, 0, 1'b0, a, lat, p, c, held);
      exp = model_step(k, 0, 1'b0);
      checks++;
      if (p !== OW'(exp)) begin
        errors++; $display("FAIL arst_after[%0d]: got %0d want %0d", k, p, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_clear();
    test_random();
    test_round_robin();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
